vga_sync_gen: RTL and testbench

- Timing source for the VGA display path. Divides the system clock down to a pixel tick, runs horizontal and vertical counters, and drives hsync/vsync.
- Publishes pixel_x, pixel_y and video_on to the pixel generation block. That block's screen-refresh detect (pixel_y==481, pixel_x==0) relies on this counter scheme.
- Sits between the top level and pixel generation. The rgb output of pixel generation is sampled alongside hsync/vsync at the pins.

---
 rtl/vga_sync_gen.sv | 108 ++++++++++
 tb/tb_vga_sync_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing source.
// Divides clk down to a pixel tick, runs the horizontal and vertical counters,
// and produces registered hsync/vsync/video_on aligned with pixel_x/pixel_y.
// Optional feature macro: VGA_FRAME_CNT_EN adds an 8-bit wrapping frame counter
// output (frame_cnt) that steps on the (0,0) wrap.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
`ifdef VGA_FRAME_CNT_EN
    output logic [9:0] pixel_y,
    output logic [7:0] frame_cnt
`else
    output logic [9:0] pixel_y
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick_next;
    logic             x_wrap;
    logic             y_wrap;
    logic [9:0]       x_next;
    logic [9:0]       y_next;

    // The pixel step happens on the same edge that raises p_tick, so p_tick
    // high marks the clk in which freshly advanced counters are presented.
    assign tick_next = (div_cnt == DIV_LAST);
    assign x_wrap    = (pixel_x == H_LAST);
    assign y_wrap    = (pixel_y == V_LAST);

    // Next-state counters; sync outputs are decoded from these so they carry no lag.
    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (tick_next) begin
            x_next = x_wrap ? 10'd0 : pixel_x + 10'd1;
            if (x_wrap)
                y_next = y_wrap ? 10'd0 : pixel_y + 10'd1;
        end
    end

    // Clock divider and registered pixel tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            div_cnt <= tick_next ? '0 : div_cnt + 1'b1;
            p_tick  <= tick_next;
        end
    end

    // Pixel counters and sync/blank decode from next-state values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_x  <= '0;
            pixel_y  <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b1;
        end else begin
            pixel_x  <= x_next;
            pixel_y  <= y_next;
            hsync    <= !((x_next >= HS_START) && (x_next <= HS_END));
            vsync    <= !((y_next >= VS_START) && (y_next <= VS_END));
            video_on <= (x_next < H_VIS) && (y_next < V_VIS);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter steps on the tick that takes (H_TOTAL-1, V_TOTAL-1) to (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_cnt <= '0;
        else if (tick_next && x_wrap && y_wrap)
            frame_cnt <= frame_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two instances (default timing at CLK_DIV=2, and a
// compact timing at CLK_DIV=1 so whole frames fit in the run). Every clk the
// expected state is pushed into a per-instance queue and popped at negedge.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic       hs_a, vs_a, vo_a, tk_a, hs_b, vs_b, vo_b, tk_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic [7:0] fc_a, fc_b;

    vga_sync_gen u_a (
        .clk(clk), .rst(rst_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
        .p_tick(tk_a), .pixel_x(x_a),
`ifdef VGA_FRAME_CNT_EN
        .pixel_y(y_a), .frame_cnt(fc_a)
`else
        .pixel_y(y_a)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_b (
        .clk(clk), .rst(rst_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
        .p_tick(tk_b), .pixel_x(x_b),
`ifdef VGA_FRAME_CNT_EN
        .pixel_y(y_b), .frame_cnt(fc_b)
`else
        .pixel_y(y_b)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign fc_a = 8'd0;
    assign fc_b = 8'd0;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int n_a = 0;
    int n_b = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    // Reference: state after n clk edges since release, from pixel index n/cd.
    function automatic logic [31:0] model(input int n, input int cd,
        input int hd, input int hf, input int hsw, input int hb,
        input int vd, input int vf, input int vsw, input int vb);
        int p, ht, vt, x, y, fr;
        logic tick, hsn, vsn, vo;
        ht   = hd + hf + hsw + hb;
        vt   = vd + vf + vsw + vb;
        p    = n / cd;
        x    = p % ht;
        y    = (p / ht) % vt;
`ifdef VGA_FRAME_CNT_EN
        fr   = (p / (ht * vt)) % 256;
`else
        fr   = 0;
`endif
        tick = (n > 0) && (n % cd == 0);
        hsn  = !((x >= hd + hf) && (x <= hd + hf + hsw - 1));
        vsn  = !((y >= vd + vf) && (y <= vd + vf + vsw - 1));
        vo   = (x < hd) && (y < vd);
        return {8'(fr), tick, vo, hsn, vsn, 10'(y), 10'(x)};
    endfunction

    function automatic logic [31:0] exp_a(input int n);
        return model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [31:0] exp_b(input int n);
        return model(n, 1, 8, 2, 3, 2, 6, 1, 2, 2);
    endfunction

    function automatic logic [31:0] obs_a();
        return {fc_a, tk_a, vo_a, hs_a, vs_a, y_a, x_a};
    endfunction

    function automatic logic [31:0] obs_b();
        return {fc_b, tk_b, vo_b, hs_b, vs_b, y_b, x_b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clk: advance models at posedge, push expectations, pop/compare at negedge.
    task automatic cycle();
        @(posedge clk);
        if (rst_a) n_a++;
        if (rst_b) n_b++;
        q_a.push_back(exp_a(n_a));
        q_b.push_back(exp_b(n_b));
        @(negedge clk);
        check("sb_a", obs_a(), q_a.pop_front());
        check("sb_b", obs_b(), q_b.pop_front());
    endtask

    int   ticks_a, ticks_b, hs_low_cnt, vo_fall_x, line0_n, line1_n, frame_n;
    int   y481_cnt;
    int   vs_mask;
    logic vo_seen_fall, found;

    initial begin
        ticks_a = 0; ticks_b = 0; hs_low_cnt = 0; vo_fall_x = -1;
        line0_n = -1; line1_n = -1; frame_n = -1; y481_cnt = 0; vs_mask = 0;
        vo_seen_fall = 1'b0; found = 1'b0;

        // Held in reset: reset values on both instances.
        repeat (3) cycle();
        check("reset_a", obs_a(), {8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0});
        check("reset_b", obs_b(), {8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0});

        // Release at negedge; first tick comes CLK_DIV clks later with pixel_x=1.
        rst_a = 1'b1;
        rst_b = 1'b1;
        cycle();
        check("first_edge_a_no_tick", {31'd0, tk_a}, 32'd0);
        cycle();
        check("first_tick_a", {21'd0, tk_a, y_a, x_a}, {21'd0, 1'b1, 10'd0, 10'd1});
        ticks_a = 1;
        ticks_b = 2;
        repeat (18) begin
            cycle();
            ticks_a += int'(tk_a);
            ticks_b += int'(tk_b);
        end
        check("ticks_20clk_div2", 32'(ticks_a), 32'd10);
        check("ticks_20clk_div1", 32'(ticks_b), 32'd20);

        // Long run: 257 compact frames on u_b, ~26 default lines on u_a.
        while (n_b < 257 * 165) begin
            cycle();
            if (n_a <= 1600 && tk_a && !hs_a) hs_low_cnt++;
            if (!vo_seen_fall && !vo_a) begin
                vo_seen_fall = 1'b1;
                vo_fall_x = int'(x_a);
            end
            if (tk_a && x_a == 10'd0 && y_a == 10'd1 && line0_n < 0) line0_n = n_a;
            if (tk_a && x_a == 10'd0 && y_a == 10'd2 && line1_n < 0) line1_n = n_a;
            if (n_b < 165) begin
                if (!vs_b) vs_mask |= (1 << int'(y_b));
                if (y_b == 10'd7 && x_b == 10'd0) y481_cnt++;
            end
            if (frame_n < 0 && tk_b && x_b == 10'd0 && y_b == 10'd0) frame_n = n_b;
        end
        check("hsync_low_pixels", 32'(hs_low_cnt), 32'd96);
        check("video_on_fall_x", 32'(vo_fall_x), 32'd640);
        check("line_period_clks", 32'(line1_n - line0_n), 32'd1600);
        check("vsync_low_lines_b", 32'(vs_mask), 32'h180);
        check("refresh_marker_clks_b", 32'(y481_cnt), 32'd1);
        check("frame_len_b", 32'(frame_n), 32'd165);
        check("wrap_to_origin_b", {12'd0, y_b, x_b}, 32'd0);
`ifdef VGA_FRAME_CNT_EN
        check("frame_cnt_257", {24'd0, fc_b}, 32'd1);
`endif

        // Mid-line async reset on u_a at pixel_x==123, mid-frame on u_b.
        for (int k = 0; k < 2000 && !found; k++) begin
            cycle();
            if (x_a == 10'd123 && tk_a) found = 1'b1;
        end
        check("wait_x123", {31'd0, found}, 32'd1);
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        check("async_clear_a", obs_a(), {fc_a, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0});
        check("async_clear_b", obs_b(), {fc_b, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0});
`ifdef VGA_FRAME_CNT_EN
        check("async_clear_fc", {16'd0, fc_a, fc_b}, 32'd0);
`endif
        n_a = 0;
        n_b = 0;
        repeat (2) cycle();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (200) cycle();
        check("restart_a", {12'd0, y_a, x_a}, {12'd0, 10'd0, 10'd100});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
